control_pipe: RTL and testbench

CONTROL_PIPE -- requirements
Module: control_pipe

---
 rtl/control_pipe.sv | 117 +++++++++++
 tb/tb_control_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// Control-signal pipeline for a five-stage core: carries decoder bundles ID->EX->MEM->WB,
// detects load-use hazards, inserts bubbles and applies branch flushes.
module control_pipe (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] id_wb,
  input  logic [2:0] id_m,
  input  logic [3:0] id_ex,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       br_taken,
  output logic       ex_regdst,
  output logic       ex_alusrc,
  output logic [1:0] ex_aluop,
  output logic       mem_branch,
  output logic       mem_memread,
  output logic       mem_memwrite,
  output logic       wb_regwrite,
  output logic       wb_memtoreg,
  output logic [4:0] ex_wreg,
  output logic [4:0] mem_wreg,
  output logic [4:0] wb_wreg,
  output logic       stall,
  output logic [7:0] bubble_cnt
);

  logic [1:0] idex_wb;
  logic [2:0] idex_m;
  logic [3:0] idex_ex;
  logic [4:0] idex_rt;
  logic [4:0] idex_rd;
  logic [1:0] exmem_wb;
  logic [2:0] exmem_m;
  logic [4:0] exmem_wreg;
  logic [1:0] memwb_wb;
  logic [4:0] memwb_wreg;

  logic [1:0] wb_in;
  logic [2:0] m_in;
  logic [3:0] ex_in;

  // Unknown decoder bits are forced to 0 so X never enters the pipeline.
  always_comb begin
    wb_in = '0;
    m_in  = '0;
    ex_in = '0;
    for (int i = 0; i < 2; i++) wb_in[i] = (id_wb[i] === 1'b1);
    for (int i = 0; i < 3; i++) m_in[i]  = (id_m[i] === 1'b1);
    for (int i = 0; i < 4; i++) ex_in[i] = (id_ex[i] === 1'b1);
  end

  assign ex_regdst    = idex_ex[0];
  assign ex_aluop     = idex_ex[2:1];
  assign ex_alusrc    = idex_ex[3];
  assign ex_wreg      = idex_ex[0] ? idex_rd : idex_rt;
  assign mem_branch   = exmem_m[0];
  assign mem_memread  = exmem_m[1];
  assign mem_memwrite = exmem_m[2];
  assign mem_wreg     = exmem_wreg;
  assign wb_regwrite  = memwb_wb[0];
  assign wb_memtoreg  = memwb_wb[1];
  assign wb_wreg      = memwb_wreg;

  assign stall = id_valid && idex_m[1] && (idex_rt != 5'd0) &&
                 ((idex_rt == id_rs) || (idex_rt == id_rt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_wb    <= '0;
      idex_m     <= '0;
      idex_ex    <= '0;
      idex_rt    <= '0;
      idex_rd    <= '0;
      exmem_wb   <= '0;
      exmem_m    <= '0;
      exmem_wreg <= '0;
      memwb_wb   <= '0;
      memwb_wreg <= '0;
      bubble_cnt <= '0;
    end else begin
      memwb_wb   <= exmem_wb;
      memwb_wreg <= exmem_wreg;
      if (br_taken) begin
        // Flush wins over a simultaneous load-use stall; the bubble is not counted.
        idex_wb    <= '0;
        idex_m     <= '0;
        idex_ex    <= '0;
        idex_rt    <= '0;
        idex_rd    <= '0;
        exmem_wb   <= '0;
        exmem_m    <= '0;
        exmem_wreg <= '0;
      end else begin
        exmem_wb   <= idex_wb;
        exmem_m    <= idex_m;
        exmem_wreg <= ex_wreg;
        if (stall || !id_valid) begin
          idex_wb <= '0;
          idex_m  <= '0;
          idex_ex <= '0;
          idex_rt <= '0;
          idex_rd <= '0;
        end else begin
          idex_wb <= wb_in;
          idex_m  <= m_in;
          idex_ex <= ex_in;
          idex_rt <= id_rt;
          idex_rd <= id_rd;
        end
        if (stall && (bubble_cnt != 8'hFF)) bubble_cnt <= bubble_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_control_pipe.sv
// Self-checking bench for control_pipe: per-scenario tasks push expected stage outputs
// into a cycle-stamped scoreboard that a negedge monitor drains and compares.
module tb_control_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] id_wb = '0;
  logic [2:0] id_m = '0;
  logic [3:0] id_ex = '0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic [4:0] id_rd = '0;
  logic       br_taken = 1'b0;
  logic       ex_regdst, ex_alusrc;
  logic [1:0] ex_aluop;
  logic       mem_branch, mem_memread, mem_memwrite;
  logic       wb_regwrite, wb_memtoreg;
  logic [4:0] ex_wreg, mem_wreg, wb_wreg;
  logic       stall;
  logic [7:0] bubble_cnt;

  control_pipe dut (
    .clk(clk), .rst(rst), .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .br_taken(br_taken), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
    .ex_aluop(ex_aluop), .mem_branch(mem_branch), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .ex_wreg(ex_wreg), .mem_wreg(mem_wreg), .wb_wreg(wb_wreg), .stall(stall),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  localparam int S_EXC = 0, S_MC = 1, S_WC = 2, S_EXW = 3, S_MW = 4, S_WW = 5,
                 S_CNT = 6, S_STALL = 7;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   exp_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] probe(input int sel);
    case (sel)
      S_EXC:   probe = {4'b0, ex_alusrc, ex_aluop, ex_regdst};
      S_MC:    probe = {5'b0, mem_memwrite, mem_memread, mem_branch};
      S_WC:    probe = {6'b0, wb_memtoreg, wb_regwrite};
      S_EXW:   probe = {3'b0, ex_wreg};
      S_MW:    probe = {3'b0, mem_wreg};
      S_WW:    probe = {3'b0, wb_wreg};
      S_CNT:   probe = bubble_cnt;
      S_STALL: probe = {7'b0, stall};
      default: probe = 8'h00;
    endcase
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      S_EXC:   sel_name = "ex_ctrl";
      S_MC:    sel_name = "mem_ctrl";
      S_WC:    sel_name = "wb_ctrl";
      S_EXW:   sel_name = "ex_wreg";
      S_MW:    sel_name = "mem_wreg";
      S_WW:    sel_name = "wb_wreg";
      S_CNT:   sel_name = "bubble_cnt";
      S_STALL: sel_name = "stall";
      default: sel_name = "unknown";
    endcase
  endfunction

  // Scoreboard consumer: entries due this cycle are compared half a cycle after the edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [7:0] got;
        got = probe(sb[i].sel);
        total++;
        if (got !== sb[i].val)
          $display("FAIL %s cyc=%0d got=%0h expected=%0h", sel_name(sb[i].sel), cyc, got, sb[i].val);
        else
          passed++;
        sb.delete(i);
      end
    end
  end

  task automatic push(input int c, input int sel, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                       input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic br);
    id_wb = wb; id_m = m; id_ex = ex; id_valid = v;
    id_rs = rs; id_rt = rt; id_rd = rd; br_taken = br;
  endtask

  task automatic nop_drain(input int n);
    drive(2'b00, 3'b000, 4'b0000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < n; i++) clk_step();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b1;
    #1;
    for (int s = 0; s < 8; s++) begin
      got = probe(s);
      total++;
      if (got !== 8'h00) $display("FAIL reset_%s got=%0h expected=0", sel_name(s), got);
      else passed++;
    end
    sb.delete();
    exp_cnt = 0;
    #1;
    rst = 1'b0;
    drive(2'b00, 3'b000, 4'b0000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // R-type (rd=5), I-type (rt dest), beq, R-type back to back.
  task automatic test_back_to_back();
    logic [1:0] t_wb[4]  = '{2'b01, 2'b01, 2'b00, 2'b01};
    logic [2:0] t_m[4]   = '{3'b000, 3'b000, 3'b001, 3'b000};
    logic [3:0] t_ex[4]  = '{4'b0101, 4'b1000, 4'b0010, 4'b0101};
    logic [4:0] t_rt[4]  = '{5'd2, 5'd7, 5'd4, 5'd6};
    logic [4:0] t_rd[4]  = '{5'd5, 5'd9, 5'd0, 5'd3};
    logic [4:0] t_dst[4] = '{5'd5, 5'd7, 5'd4, 5'd3};
    int n;
    for (int i = 0; i < 4; i++) begin
      drive(t_wb[i], t_m[i], t_ex[i], 1'b1, 5'd1, t_rt[i], t_rd[i], 1'b0);
      n = cyc + 1;
      push(n, S_EXC, {4'b0, t_ex[i]});
      push(n, S_EXW, {3'b0, t_dst[i]});
      push(n + 1, S_MC, {5'b0, t_m[i]});
      push(n + 1, S_MW, {3'b0, t_dst[i]});
      push(n + 2, S_WC, {6'b0, t_wb[i]});
      push(n + 2, S_WW, {3'b0, t_dst[i]});
      clk_step();
    end
    n = cyc + 1;
    push(n, S_EXC, 8'h00);
    push(n, S_EXW, 8'h00);
    push(n + 2, S_WW, 8'h00);
    nop_drain(3);
  endtask

  task automatic test_load_use();
    int n;
    drive(2'b11, 3'b010, 4'b1000, 1'b1, 5'd0, 5'd8, 5'd0, 1'b0);
    n = cyc + 1;
    push(n, S_EXC, 8'h08);
    push(n, S_EXW, 8'd8);
    push(n + 1, S_MC, 8'h02);
    push(n + 1, S_MW, 8'd8);
    push(n + 2, S_WC, 8'h03);
    push(n + 2, S_WW, 8'd8);
    clk_step();
    drive(2'b01, 3'b000, 4'b0101, 1'b1, 5'd8, 5'd3, 5'd10, 1'b0);
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL load_use_stall got=%b expected=1", stall);
    else passed++;
    exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    push(n + 1, S_EXC, 8'h00);
    push(n + 1, S_EXW, 8'h00);
    push(n + 1, S_CNT, 8'(exp_cnt));
    clk_step();
    total++;
    if (stall !== 1'b0) $display("FAIL load_use_stall_clear got=%b expected=0", stall);
    else passed++;
    push(n + 2, S_EXC, 8'h05);
    push(n + 2, S_EXW, 8'd10);
    push(n + 2, S_MC, 8'h00);
    push(n + 2, S_CNT, 8'(exp_cnt));
    push(n + 3, S_MW, 8'd10);
    push(n + 3, S_WC, 8'h00);
    push(n + 4, S_WC, 8'h01);
    push(n + 4, S_WW, 8'd10);
    clk_step();
    nop_drain(3);
  endtask

  task automatic test_load_r0();
    int n;
    drive(2'b11, 3'b010, 4'b1000, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    clk_step();
    n = cyc + 1;
    drive(2'b01, 3'b000, 4'b0101, 1'b1, 5'd0, 5'd0, 5'd11, 1'b0);
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL load_r0_stall got=%b expected=0", stall);
    else passed++;
    push(n, S_EXC, 8'h05);
    push(n, S_EXW, 8'd11);
    push(n, S_CNT, 8'(exp_cnt));
    clk_step();
    nop_drain(3);
  endtask

  task automatic test_flush();
    int e1;
    drive(2'b01, 3'b000, 4'b0101, 1'b1, 5'd1, 5'd2, 5'd12, 1'b0);
    e1 = cyc + 1;
    push(e1, S_EXC, 8'h05);
    push(e1 + 1, S_MC, 8'h00);
    push(e1 + 1, S_MW, 8'd12);
    push(e1 + 2, S_WC, 8'h01);
    push(e1 + 2, S_WW, 8'd12);
    clk_step();
    drive(2'b11, 3'b010, 4'b1000, 1'b1, 5'd0, 5'd8, 5'd0, 1'b0);
    push(e1 + 1, S_EXC, 8'h08);
    push(e1 + 1, S_EXW, 8'd8);
    clk_step();
    drive(2'b01, 3'b000, 4'b0101, 1'b1, 5'd8, 5'd3, 5'd10, 1'b1);
    push(e1 + 2, S_EXC, 8'h00);
    push(e1 + 2, S_EXW, 8'h00);
    push(e1 + 2, S_MC, 8'h00);
    push(e1 + 2, S_MW, 8'h00);
    push(e1 + 2, S_CNT, 8'(exp_cnt));
    clk_step();
    push(e1 + 3, S_WC, 8'h00);
    push(e1 + 3, S_WW, 8'h00);
    push(e1 + 3, S_CNT, 8'(exp_cnt));
    nop_drain(3);
  endtask

  task automatic test_xsan();
    int n;
    drive({1'bx, 1'b0}, 3'b100, {1'b1, 2'b00, 1'bx}, 1'b1, 5'd1, 5'd4, 5'd6, 1'b0);
    n = cyc + 1;
    push(n, S_EXC, 8'h08);
    push(n, S_EXW, 8'd4);
    push(n + 1, S_MC, 8'h04);
    push(n + 1, S_MW, 8'd4);
    push(n + 2, S_WC, 8'h00);
    push(n + 2, S_WW, 8'd4);
    clk_step();
    nop_drain(3);
  endtask

  task automatic test_saturate();
    int nst = 0;
    test_reset();
    drive(2'b11, 3'b010, 4'b1000, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0);
    for (int i = 1; i <= 520; i++) begin
      clk_step();
      if (stall === 1'b1) nst++;
      if (i == 508) begin
        total++;
        if (bubble_cnt !== 8'd254) $display("FAIL sat_cnt_254 got=%0d expected=254", bubble_cnt);
        else passed++;
      end
      if (i == 510) begin
        total++;
        if (bubble_cnt !== 8'd255) $display("FAIL sat_cnt_255 got=%0d expected=255", bubble_cnt);
        else passed++;
      end
    end
    total++;
    if (bubble_cnt !== 8'd255) $display("FAIL sat_cnt_held got=%0d expected=255", bubble_cnt);
    else passed++;
    total++;
    if (nst !== 260) $display("FAIL sat_stall_count got=%0d expected=260", nst);
    else passed++;
    clk_step();
    total++;
    if (stall !== 1'b1) $display("FAIL sat_mid_stall got=%b expected=1", stall);
    else passed++;
    #1;
    test_reset();
    drive(2'b01, 3'b000, 4'b0101, 1'b1, 5'd1, 5'd2, 5'd5, 1'b0);
    push(cyc + 1, S_EXC, 8'h05);
    push(cyc + 1, S_EXW, 8'd5);
    push(cyc + 1, S_CNT, 8'h00);
    clk_step();
    nop_drain(3);
  endtask

  initial begin
    test_reset();
    clk_step();
    test_back_to_back();
    test_load_use();
    test_load_r0();
    test_flush();
    test_xsan();
    test_saturate();
    nop_drain(2);
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drained got=%0d expected=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
